ysyx_23060332_wb_arb: RTL and testbench
=======================================

Name: ysyx_23060332_wb_arb

Overview:
Writeback arbiter and scoreboard for the 2-read/1-write general register file. Shares the single regfile write port among N_REQ writeback sources (ALU, LSU load, CSR) using round-robin arbitration with a one-cycle registered output stage. Tracks in-flight destination registers issued by the IDU and reports read-after-write hazards on the two IDU read addresses so the IDU can stall.

Parameters:
N_REQ, 3, number of writeback requesters (2..4)
CNT_W, 2, width of per-register pending-write counter (max outstanding writes per rd = 2^CNT_W-1)

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  N_REQ  requester i has a writeback pending
req_ready  out  N_REQ  requester i's writeback accepted this cycle
req_waddr  in  N_REQ*5  packed destination addresses, requester i at [5i+4:5i]
req_wdata  in  N_REQ*32  packed write data, requester i at [32i+31:32i]
reg_waddr  out  5  regfile write address
reg_wdata  out  32  regfile write data
reg_wen  out  1  regfile write enable
issue_valid  in  1  IDU issues an instruction that will write issue_rd
issue_rd  in  5  destination of issued instruction
issue_ready  out  1  scoreboard can accept the issue
rs1_addr  in  5  IDU read address 1
rs2_addr  in  5  IDU read address 2
rs1_busy  out  1  rs1 has an outstanding write
rs2_busy  out  1  rs2 has an outstanding write
err_underflow  out  1  sticky: commit to a register with zero pending count

Behaviour:
- Reset: rst is synchronous and active-high, clock is clk. While rst is asserted: reg_wen=0, reg_waddr=0, reg_wdata=0, rr_ptr=0, all counters=0, err_underflow=0. The same applies when rst asserts mid-operation. In-flight writebacks are dropped.
- Arbitration is combinational within the cycle. Search starts at index rr_ptr and wraps upward modulo N_REQ. The first i with req_valid[i]=1 is granted. At most one grant per cycle.
- req_ready[i] = grant[i]. The write port never back-pressures, so some request is accepted every cycle any request is valid.
- Requesters hold valid, waddr and wdata stable until ready. Deasserting valid before ready is permitted; that request is simply not granted.
- On a grant to i: rr_ptr <= (i+1) mod N_REQ. With no grant, rr_ptr holds.
- Output stage, latency 1: at the next edge reg_waddr <= req_waddr[i], reg_wdata <= req_wdata[i], reg_wen <= 1 if waddr != 0.
  - A grant with waddr=0 is accepted and consumed, but reg_wen=0.
  - With no grant, reg_wen <= 0 and addr/data hold.
- The regfile captures the write at the edge following reg_wen=1.
- Scoreboard, per register r in 1..31: pend[r] is CNT_W bits.
  - inc = issue_valid & issue_ready & issue_rd==r.
  - dec = reg_wen & reg_waddr==r. The decrement occurs on the same edge that the regfile writes, so busy clears exactly when the new value is readable.
  - inc & dec in the same cycle: pend unchanged.
  - pend[0] is always 0. Issues to x0 are ignored and issue_ready=1.
- issue_ready = 0 iff issue_rd != 0 and pend[issue_rd] is all-ones; otherwise 1. issue_ready is combinational.
- dec with pend[r]=0: pend stays 0 and err_underflow <= 1. err_underflow is sticky until rst.
- rsN_busy = (rsN_addr != 0) & (pend[rsN_addr] != 0), combinational. No bypass: a write in the reg_wen cycle still reports busy.

Decomposition:
- Shared define file: RegAddrBus, RegDataBus, and a ZeroReg constant (5'd0).
- One sub-module, ysyx_23060332_rr_arb: parameter N, inputs req[N], clk, rst; output grant[N] (one-hot). It owns rr_ptr.
- Scoreboard counters and the output register stay in the top.

Test Plan:
- Single writer: req_valid=3'b001, waddr=5, wdata=0xDEADBEEF at cycle 0 -> req_ready[0]=1 at cycle 0; reg_wen=1, reg_waddr=5, reg_wdata=0xDEADBEEF at cycle 1; reg_wen=0 at cycle 2.
- Round-robin fairness: all three valid continuously after reset -> grants 0,1,2,0,1,2 on consecutive cycles; no requester waits more than N_REQ-1 cycles.
- x0 writeback: req 1 valid, waddr=0, wdata=0x1234 -> req_ready[1]=1; next cycle reg_wen=0; pend unchanged; err_underflow=0.
- Scoreboard RAW:
  - issue rd=7 at cycle 0 -> rs1_addr=7 gives rs1_busy=1 from cycle 1.
  - Writeback rd=7 granted at cycle 3 -> reg_wen at cycle 4; rs1_busy=0 from cycle 5.
  - Two issues to rd=7 -> busy stays 1 until both writes commit.
- Saturation and simultaneity:
  - With CNT_W=2, three issues to rd=9 -> issue_ready=0 for rd=9; issue_ready=1 for rd=10.
  - Issue rd=9 in the same cycle reg_wen commits rd=9 -> pend[9] unchanged.
- Reset mid-flight: pend[4]=2 and reg_wen=1, assert rst one cycle -> reg_wen=0, rs1_busy(4)=0, rr_ptr=0 (next grant with all valid goes to 0), err_underflow=0.

Source files
------------

// File: rtl/ysyx_23060332_wb_arb_pkg.sv
// Shared regfile bus types for the writeback arbiter and scoreboard.
package ysyx_23060332_wb_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;
    typedef logic [REG_DATA_W-1:0] reg_data_bus_t;

    // x0 is hardwired to zero: never written, never busy.
    localparam reg_addr_bus_t ZERO_REG = 5'd0;

endpackage

// File: rtl/ysyx_23060332_rr_arb.sv
// Round-robin arbiter: one-hot grant, search starts at rr_ptr and wraps.
module ysyx_23060332_rr_arb #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] idx;
    logic [PTR_W:0]   sum;
    logic             gnt_any;

    // Scan N slots starting at rr_ptr; the first active request wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N))
                sum = sum - (PTR_W+1)'(N);
            idx = sum[PTR_W-1:0];
            if (!gnt_any && req[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = idx;
                gnt_any    = 1'b1;
            end
        end
    end

    // Next search starts just past the winner; hold when nobody asked.
    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (gnt_any)
            rr_ptr <= (gnt_idx == PTR_W'(N-1)) ? '0 : gnt_idx + PTR_W'(1);
    end

endmodule

// File: rtl/ysyx_23060332_wb_arb.sv
// Writeback arbiter for the single regfile write port, plus a per-register
// pending-write scoreboard that reports RAW hazards to the IDU.
module ysyx_23060332_wb_arb
    import ysyx_23060332_wb_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*5-1:0]    req_waddr,
    input  logic [N_REQ*32-1:0]   req_wdata,
    output logic [4:0]            reg_waddr,
    output logic [31:0]           reg_wdata,
    output logic                  reg_wen,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_rd,
    output logic                  issue_ready,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  err_underflow
);

    logic [N_REQ-1:0]                  grant;
    reg_addr_bus_t                     sel_addr;
    reg_data_bus_t                     sel_data;
    logic [NUM_REGS-1:0][CNT_W-1:0]    pend;
    logic [NUM_REGS-1:0]               inc_vec;
    logic [NUM_REGS-1:0]               dec_vec;

    ysyx_23060332_rr_arb #(.N(N_REQ)) u_rr_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .grant (grant)
    );

    // The write port never stalls, so the grant is the handshake.
    assign req_ready = grant;

    // Select the granted requester's address and data.
    always_comb begin
        sel_addr = ZERO_REG;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_waddr[5*i +: 5];
                sel_data = req_wdata[32*i +: 32];
            end
        end
    end

    // One-cycle output stage; an x0 grant is consumed without a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wen   <= 1'b0;
            reg_waddr <= ZERO_REG;
            reg_wdata <= '0;
        end else if (|grant) begin
            reg_wen   <= (sel_addr != ZERO_REG);
            reg_waddr <= sel_addr;
            reg_wdata <= sel_data;
        end else begin
            reg_wen   <= 1'b0;
        end
    end

    // Issue is refused only when the destination counter is saturated.
    assign issue_ready = !((issue_rd != ZERO_REG) && (&pend[issue_rd]));

    // No bypass: busy stays up through the reg_wen cycle.
    assign rs1_busy = (rs1_addr != ZERO_REG) && (pend[rs1_addr] != '0);
    assign rs2_busy = (rs2_addr != ZERO_REG) && (pend[rs2_addr] != '0);

    // Per-register increment (issue) and decrement (commit) strobes.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc_vec[r] = issue_valid && issue_ready && (issue_rd == 5'(r));
            dec_vec[r] = reg_wen && (reg_waddr == 5'(r));
        end
    end

    // Counter update; decrement lands on the edge the regfile writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend          <= '0;
            err_underflow <= 1'b0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                case ({inc_vec[r], dec_vec[r]})
                    2'b10: pend[r] <= pend[r] + 1'b1;
                    2'b01: begin
                        if (pend[r] == '0)
                            err_underflow <= 1'b1;
                        else
                            pend[r] <= pend[r] - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_wb_arb.sv
// Bench for the writeback arbiter / scoreboard: one vector per clock cycle,
// combinational outputs checked mid-cycle, registered writes via a queue.
module tb_ysyx_23060332_wb_arb;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*5-1:0]  req_waddr;
    logic [N*32-1:0] req_wdata;
    logic [4:0]      reg_waddr;
    logic [31:0]     reg_wdata;
    logic            reg_wen;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            issue_ready;
    logic [4:0]      rs1_addr, rs2_addr;
    logic            rs1_busy, rs2_busy;
    logic            err_underflow;

    always #5 clk = ~clk;

    ysyx_23060332_wb_arb #(.N_REQ(N), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_waddr(req_waddr), .req_wdata(req_wdata),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wen(reg_wen),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .err_underflow(err_underflow)
    );

    typedef struct {
        bit        rst;
        bit [2:0]  vld;
        bit [4:0]  wa;
        bit [31:0] wd;
        bit        iv;
        bit [4:0]  ird;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
        bit [2:0]  erdy;
        bit        eir;
        bit        eb1;
        bit        eb2;
        bit        eerr;
        bit        ewen;
        bit [4:0]  ewa;
        bit [31:0] ewd;
    } vec_t;

    typedef struct {
        bit        wen;
        bit        chk_ad;
        bit [4:0]  a;
        bit [31:0] d;
    } wexp_t;

    vec_t  tbl[$];
    wexp_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    row   = 0;

    function automatic vec_t mk(bit r, bit [2:0] vld, bit [4:0] wa, bit [31:0] wd,
                                bit iv, bit [4:0] ird, bit [4:0] rs1, bit [4:0] rs2,
                                bit [2:0] erdy, bit eir, bit eb1, bit eb2, bit eerr,
                                bit ewen, bit [4:0] ewa, bit [31:0] ewd);
        vec_t v;
        v.rst = r; v.vld = vld; v.wa = wa; v.wd = wd;
        v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
        v.erdy = erdy; v.eir = eir; v.eb1 = eb1; v.eb2 = eb2; v.eerr = eerr;
        v.ewen = ewen; v.ewa = ewa; v.ewd = ewd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    // Drive one cycle of stimulus; idle lanes carry junk so a wrong mux pick shows.
    task automatic apply(input vec_t v);
        wexp_t w;
        rst         = v.rst;
        req_valid   = v.vld;
        issue_valid = v.iv;
        issue_rd    = v.ird;
        rs1_addr    = v.rs1;
        rs2_addr    = v.rs2;
        for (int i = 0; i < N; i++) begin
            req_waddr[5*i +: 5]   = v.vld[i] ? v.wa : 5'h1F;
            req_wdata[32*i +: 32] = v.vld[i] ? v.wd : (32'hBAD0_0000 | 32'(i));
        end
        #1;
        if (!v.rst) begin
            chk("req_ready",     32'(req_ready),     32'(v.erdy));
            chk("issue_ready",   32'(issue_ready),   32'(v.eir));
            chk("rs1_busy",      32'(rs1_busy),      32'(v.eb1));
            chk("rs2_busy",      32'(rs2_busy),      32'(v.eb2));
            chk("err_underflow", 32'(err_underflow), 32'(v.eerr));
        end
        exp_q.push_back('{v.ewen, v.ewen | v.rst, v.ewa, v.ewd});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard row %0d: got empty queue expected entry", row);
        end else begin
            w = exp_q.pop_front();
            chk("reg_wen", 32'(reg_wen), 32'(w.wen));
            if (w.chk_ad) begin
                chk("reg_waddr", 32'(reg_waddr), 32'(w.a));
                chk("reg_wdata", reg_wdata, w.d);
            end
        end
        row++;
    endtask

    initial begin
        // Reset, single writer, x0 writeback, fairness, saturation, simultaneity, underflow.
        tbl.push_back(mk(1,3'b000,0,0,             0,0, 0,0, 3'b000,1,0,0,0, 0,0,0));
        tbl.push_back(mk(1,3'b000,0,0,             0,0, 0,0, 3'b000,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b000,0,0,             1,5, 5,0, 3'b000,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b001,5,32'hDEADBEEF,  0,0, 5,0, 3'b001,1,1,0,0, 1,5,32'hDEADBEEF));
        tbl.push_back(mk(0,3'b000,0,0,             0,0, 5,0, 3'b000,1,1,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b000,0,0,             0,0, 5,0, 3'b000,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b010,0,32'h1234,      0,0, 0,0, 3'b010,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b000,0,0,             0,0, 0,0, 3'b000,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b111,0,0,             0,0, 0,0, 3'b100,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b111,0,0,             0,0, 0,0, 3'b001,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b111,0,0,             0,0, 0,0, 3'b010,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b111,0,0,             0,0, 0,0, 3'b100,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b111,0,0,             0,0, 0,0, 3'b001,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b111,0,0,             0,0, 0,0, 3'b010,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b000,0,0,             1,9, 9,0, 3'b000,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b000,0,0,             1,9, 9,0, 3'b000,1,1,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b000,0,0,             1,9, 9,0, 3'b000,1,1,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b000,0,0,             1,9, 0,9, 3'b000,0,0,1,0, 0,0,0));
        tbl.push_back(mk(0,3'b000,0,0,             1,10,10,9, 3'b000,1,0,1,0, 0,0,0));
        tbl.push_back(mk(0,3'b001,10,32'hAA,       0,0, 10,0, 3'b001,1,1,0,0, 1,10,32'hAA));
        tbl.push_back(mk(0,3'b000,0,0,             1,10,10,0, 3'b000,1,1,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b010,10,32'hBB,       0,0, 10,0, 3'b010,1,1,0,0, 1,10,32'hBB));
        tbl.push_back(mk(0,3'b000,0,0,             0,0, 10,0, 3'b000,1,1,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b000,0,0,             0,0, 10,0, 3'b000,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b100,3,32'h33,        0,0, 0,0, 3'b100,1,0,0,0, 1,3,32'h33));
        tbl.push_back(mk(0,3'b000,0,0,             0,0, 0,0, 3'b000,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,3'b000,0,0,             0,0, 9,0, 3'b000,1,1,0,1, 0,0,0));
        foreach (tbl[i]) apply(tbl[i]);

        // Reset clears sticky error and counters; then fairness from pointer 0.
        apply(mk(1,3'b000,0,0,         0,0, 0,0, 3'b000,1,0,0,0, 0,0,0));
        apply(mk(0,3'b000,0,0,         0,9, 9,0, 3'b000,1,0,0,0, 0,0,0));
        for (int k = 0; k < 6; k++)
            apply(mk(0,3'b111,0,0,     0,0, 0,0, 3'(1 << (k % 3)),1,0,0,0, 0,0,0));

        // Two issues to x7: busy holds until the second commit is written.
        apply(mk(0,3'b000,0,0,         1,7, 7,0, 3'b000,1,0,0,0, 0,0,0));
        apply(mk(0,3'b000,0,0,         1,7, 7,0, 3'b000,1,1,0,0, 0,0,0));
        apply(mk(0,3'b001,7,32'h77,    0,0, 7,0, 3'b001,1,1,0,0, 1,7,32'h77));
        apply(mk(0,3'b000,0,0,         0,0, 7,0, 3'b000,1,1,0,0, 0,0,0));
        apply(mk(0,3'b000,0,0,         0,0, 7,0, 3'b000,1,1,0,0, 0,0,0));
        apply(mk(0,3'b010,7,32'h78,    0,0, 7,0, 3'b010,1,1,0,0, 1,7,32'h78));
        apply(mk(0,3'b000,0,0,         0,0, 7,0, 3'b000,1,1,0,0, 0,0,0));
        apply(mk(0,3'b000,0,0,         0,0, 7,0, 3'b000,1,0,0,0, 0,0,0));

        // Reset while x4 has two pending and a write is on the port.
        apply(mk(0,3'b000,0,0,         1,4, 4,0, 3'b000,1,0,0,0, 0,0,0));
        apply(mk(0,3'b000,0,0,         1,4, 4,0, 3'b000,1,1,0,0, 0,0,0));
        apply(mk(0,3'b001,4,32'h44,    0,0, 4,0, 3'b001,1,1,0,0, 1,4,32'h44));
        apply(mk(1,3'b001,4,32'h44,    0,0, 4,0, 3'b000,1,0,0,0, 0,0,0));
        apply(mk(0,3'b111,0,0,         0,0, 4,0, 3'b001,1,0,0,0, 0,0,0));
        apply(mk(0,3'b000,0,0,         0,0, 4,0, 3'b000,1,0,0,0, 0,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
